keypad_scanner: RTL and testbench



---
 rtl/vending_pkg.sv | 34 +++
 rtl/keypad_scanner_if.sv | 24 ++
 rtl/kp_sync.sv | 21 ++
 rtl/keypad_scanner.sv | 117 +++++++++++
 tb/tb_keypad_scanner.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared keypad encodings and row-scan state type
package vending_pkg;

   localparam logic [2:0] COL_L    = 3'b100;
   localparam logic [2:0] COL_M    = 3'b010;
   localparam logic [2:0] COL_R    = 3'b001;
   localparam logic [2:0] COL_NONE = 3'b000;

   localparam logic [3:0] ROW_TOP  = 4'b1000;
   localparam logic [3:0] ROW_UP   = 4'b0100;
   localparam logic [3:0] ROW_LOW  = 4'b0010;
   localparam logic [3:0] ROW_BOT  = 4'b0001;
   localparam logic [3:0] ROW_NONE = 4'b0000;

   // State value equals the index of the row being driven low.
   typedef enum logic [1:0] {
      ROW0 = 2'd0,
      ROW1 = 2'd1,
      ROW2 = 2'd2,
      ROW3 = 2'd3
   } row_state_t;

   typedef struct packed {
      logic [2:0] col;
      logic [3:0] row;
   } key_t;

   localparam key_t KEY_NONE = '{col: COL_NONE, row: ROW_NONE};

   function automatic logic [3:0] row_drive(input row_state_t s);
      return ~(4'b0001 << s);
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix lines and debounced key result
interface keypad_scanner_if;
   logic [2:0] kp_col_in;
   logic [3:0] kp_row_out;
   logic [2:0] coluna_out;
   logic [3:0] linha_out;
   logic       key_strobe_out;

   modport slave (
      input  kp_col_in,
      output kp_row_out,
      output coluna_out,
      output linha_out,
      output key_strobe_out
   );

   modport master (
      output kp_col_in,
      input  kp_row_out,
      input  coluna_out,
      input  linha_out,
      input  key_strobe_out
   );
endinterface

// File: rtl/kp_sync.sv
// rtl/kp_sync.sv - 3-bit two-flop synchronizer, resets to idle (all ones)
module kp_sync (
   input  logic       clock_in,
   input  logic       reset_in,
   input  logic [2:0] d,
   output logic [2:0] q
);

   logic [2:0] meta;

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         meta <= 3'b111;
         q    <= 3'b111;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 3x4 keypad row scanner with whole-frame debounce
module keypad_scanner
   import vending_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 8
) (
   input  logic            clock_in,
   input  logic            reset_in,
   keypad_scanner_if.slave kp
);

   localparam int             DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]     DEB_MAX  = 4'(DEBOUNCE_SCANS);

   logic [2:0]       col_sync;
   logic [DIV_W-1:0] div;
   logic             slot_end;
   logic             frame_end;
   row_state_t       state, state_nxt;
   logic [3:1][2:0]  hits;
   logic [11:0]      frame_bits;
   key_t             cand, last_cand, out_key;
   logic [3:0]       stable_cnt;
   logic             strobe;

   kp_sync u_sync (
      .clock_in (clock_in),
      .reset_in (reset_in),
      .d        (kp.kp_col_in),
      .q        (col_sync)
   );

   assign slot_end  = (div == DIV_LAST);
   assign frame_end = slot_end && (state == ROW0);

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) div <= '0;
      else if (slot_end) div <= '0;
      else div <= div + 1'b1;
   end

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) state <= ROW3;
      else state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (slot_end) begin
         case (state)
            ROW3: state_nxt = ROW2;
            ROW2: state_nxt = ROW1;
            ROW1: state_nxt = ROW0;
            ROW0: state_nxt = ROW3;
            default: state_nxt = ROW3;
         endcase
      end
   end

   always_comb begin
      kp.kp_row_out = row_drive(state);
   end

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         hits <= '0;
      end else if (slot_end) begin
         case (state)
            ROW3: hits[3] <= ~col_sync;
            ROW2: hits[2] <= ~col_sync;
            ROW1: hits[1] <= ~col_sync;
            default: ;
         endcase
      end
   end

   // Bottom row is taken live on the frame-end cycle, so it is never stored.
   assign frame_bits = {hits[3], hits[2], hits[1], ~col_sync};

   always_comb begin
      cand = KEY_NONE;
      if ($countones(frame_bits) == 1) begin
         cand.col = hits[3] | hits[2] | hits[1] | ~col_sync;
         cand.row = {|hits[3], |hits[2], |hits[1], |(~col_sync)};
      end
   end

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         last_cand  <= KEY_NONE;
         stable_cnt <= '0;
         out_key    <= KEY_NONE;
         strobe     <= 1'b0;
      end else begin
         strobe <= 1'b0;
         if (frame_end) begin
            if (cand == last_cand) begin
               if (stable_cnt != DEB_MAX) stable_cnt <= stable_cnt + 4'd1;
               if (stable_cnt == DEB_MAX - 4'd1) begin
                  out_key <= last_cand;
                  strobe  <= (last_cand != KEY_NONE);
               end
            end else begin
               stable_cnt <= '0;
               last_cand  <= cand;
            end
         end
      end
   end

   assign kp.coluna_out     = out_key.col;
   assign kp.linha_out      = out_key.row;
   assign kp.key_strobe_out = strobe;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner at SCAN_DIV=4, DEBOUNCE_SCANS=3
module tb_keypad_scanner;

   // Key index = row*3 + col, row 3 = top, col 2 = left.
   localparam int K1    = 11;
   localparam int K3    = 9;
   localparam int K5    = 7;
   localparam int K9    = 3;
   localparam int KSTAR = 2;

   logic        clock_in = 1'b0;
   logic        reset_in = 1'b1;
   logic [11:0] pressed  = '0;
   int          errors   = 0;
   int          checks   = 0;
   int          strobes  = 0;
   bit          nonzero_seen = 1'b0;
   logic [3:0]  row_seq [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

   keypad_scanner_if kp ();

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
      .clock_in (clock_in),
      .reset_in (reset_in),
      .kp       (kp)
   );

   always #5 clock_in = ~clock_in;

   // Physical keypad: a pressed key pulls its column low while its row is driven.
   always_comb begin
      kp.kp_col_in = 3'b111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (pressed[r*3+c] && !kp.kp_row_out[r]) kp.kp_col_in[c] = 1'b0;
   end

   always @(negedge clock_in) begin
      if (kp.key_strobe_out) strobes++;
      if (kp.coluna_out != 3'b000 || kp.linha_out != 4'b0000) nonzero_seen = 1'b1;
   end

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clock_in);
      #1;
   endtask

   task automatic do_reset;
      @(negedge clock_in) reset_in = 1'b1;
      @(negedge clock_in) reset_in = 1'b0;
   endtask

   task automatic test_reset;
      reset_in = 1'b1;
      pressed  = '0;
      @(negedge clock_in);
      checks++; if (kp.kp_row_out !== 4'b0111) begin errors++; $display("FAIL reset_row got %b exp 0111", kp.kp_row_out); end
      checks++; if (kp.coluna_out !== 3'b000) begin errors++; $display("FAIL reset_col got %b exp 000", kp.coluna_out); end
      checks++; if (kp.linha_out !== 4'b0000) begin errors++; $display("FAIL reset_row_out got %b exp 0000", kp.linha_out); end
      checks++; if (kp.key_strobe_out !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0", kp.key_strobe_out); end
      reset_in = 1'b0;
   endtask

   task automatic test_idle;
      int s0;
      int bad;
      pressed = '0;
      do_reset();
      s0  = strobes;
      bad = 0;
      if (kp.kp_row_out !== row_seq[0]) bad++;
      for (int i = 1; i <= 32; i++) begin
         wait_edges(1);
         if (kp.kp_row_out !== row_seq[(i/4)%4]) begin
            bad++;
            $display("FAIL idle_row cycle %0d got %b exp %b", i, kp.kp_row_out, row_seq[(i/4)%4]);
         end
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL idle_row_seq got %0d bad cycles exp 0", bad); end
      checks++; if ({kp.coluna_out, kp.linha_out} !== 7'b0) begin errors++; $display("FAIL idle_out got %b exp 0", {kp.coluna_out, kp.linha_out}); end
      checks++; if (strobes !== s0) begin errors++; $display("FAIL idle_strobe got %0d pulses exp 0", strobes - s0); end
   endtask

   task automatic test_hold_5;
      int s0;
      int bad;
      pressed = '0;
      pressed[K5] = 1'b1;
      do_reset();
      s0 = strobes;
      wait_edges(63);
      checks++; if ({kp.coluna_out, kp.linha_out} !== 7'b0) begin errors++; $display("FAIL hold5_early got %b exp 0", {kp.coluna_out, kp.linha_out}); end
      wait_edges(1);
      checks++; if (kp.coluna_out !== 3'b010) begin errors++; $display("FAIL hold5_col got %b exp 010", kp.coluna_out); end
      checks++; if (kp.linha_out !== 4'b0100) begin errors++; $display("FAIL hold5_row got %b exp 0100", kp.linha_out); end
      checks++; if (kp.key_strobe_out !== 1'b1) begin errors++; $display("FAIL hold5_strobe got %b exp 1", kp.key_strobe_out); end
      wait_edges(1);
      checks++; if (kp.key_strobe_out !== 1'b0) begin errors++; $display("FAIL hold5_strobe_len got %b exp 0", kp.key_strobe_out); end
      bad = 0;
      repeat (80) begin
         wait_edges(1);
         if (kp.coluna_out !== 3'b010 || kp.linha_out !== 4'b0100) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL hold5_steady got %0d bad cycles exp 0", bad); end
      checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL hold5_pulses got %0d exp 1", strobes - s0); end
   endtask

   task automatic test_bounce;
      int s0;
      pressed = '0;
      do_reset();
      nonzero_seen = 1'b0;
      s0 = strobes;
      repeat (10) begin
         pressed[K5] = ~pressed[K5];
         wait_edges(10);
      end
      pressed = '0;
      wait_edges(96);
      checks++; if (nonzero_seen !== 1'b0) begin errors++; $display("FAIL bounce_out got nonzero exp 0"); end
      checks++; if (strobes !== s0) begin errors++; $display("FAIL bounce_strobe got %0d pulses exp 0", strobes - s0); end
   endtask

   task automatic test_two_keys;
      int s0;
      pressed = '0;
      pressed[K1] = 1'b1;
      pressed[K9] = 1'b1;
      do_reset();
      s0 = strobes;
      wait_edges(96);
      checks++; if ({kp.coluna_out, kp.linha_out} !== 7'b0) begin errors++; $display("FAIL two_out got %b exp 0", {kp.coluna_out, kp.linha_out}); end
      checks++; if (strobes !== s0) begin errors++; $display("FAIL two_strobe got %0d pulses exp 0", strobes - s0); end
      pressed[K9] = 1'b0;
      wait_edges(63);
      checks++; if ({kp.coluna_out, kp.linha_out} !== 7'b0) begin errors++; $display("FAIL two_early got %b exp 0", {kp.coluna_out, kp.linha_out}); end
      wait_edges(1);
      checks++; if ({kp.coluna_out, kp.linha_out} !== 7'b100_1000) begin errors++; $display("FAIL two_key1 got %b exp 1001000", {kp.coluna_out, kp.linha_out}); end
      checks++; if (kp.key_strobe_out !== 1'b1) begin errors++; $display("FAIL two_key1_strobe got %b exp 1", kp.key_strobe_out); end
      wait_edges(2);
      checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL two_pulses got %0d exp 1", strobes - s0); end
   endtask

   task automatic test_star_release;
      int s0;
      pressed = '0;
      pressed[KSTAR] = 1'b1;
      do_reset();
      s0 = strobes;
      wait_edges(63);
      checks++; if ({kp.coluna_out, kp.linha_out} !== 7'b0) begin errors++; $display("FAIL star_early got %b exp 0", {kp.coluna_out, kp.linha_out}); end
      wait_edges(1);
      checks++; if ({kp.coluna_out, kp.linha_out} !== 7'b100_0001) begin errors++; $display("FAIL star_out got %b exp 1000001", {kp.coluna_out, kp.linha_out}); end
      checks++; if (kp.key_strobe_out !== 1'b1) begin errors++; $display("FAIL star_strobe got %b exp 1", kp.key_strobe_out); end
      pressed = '0;
      wait_edges(63);
      checks++; if ({kp.coluna_out, kp.linha_out} !== 7'b100_0001) begin errors++; $display("FAIL star_hold got %b exp 1000001", {kp.coluna_out, kp.linha_out}); end
      wait_edges(1);
      checks++; if ({kp.coluna_out, kp.linha_out} !== 7'b0) begin errors++; $display("FAIL star_release got %b exp 0", {kp.coluna_out, kp.linha_out}); end
      checks++; if (kp.key_strobe_out !== 1'b0) begin errors++; $display("FAIL star_release_strobe got %b exp 0", kp.key_strobe_out); end
      wait_edges(2);
      checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL star_pulses got %0d exp 1", strobes - s0); end
   endtask

   task automatic test_reset_mid;
      int s0;
      pressed = '0;
      pressed[K3] = 1'b1;
      do_reset();
      wait_edges(64);
      checks++; if ({kp.coluna_out, kp.linha_out} !== 7'b001_1000) begin errors++; $display("FAIL mid_first got %b exp 0011000", {kp.coluna_out, kp.linha_out}); end
      wait_edges(20);
      @(negedge clock_in) reset_in = 1'b1;
      @(posedge clock_in);
      #1;
      checks++; if ({kp.coluna_out, kp.linha_out} !== 7'b0) begin errors++; $display("FAIL mid_rst_out got %b exp 0", {kp.coluna_out, kp.linha_out}); end
      checks++; if (kp.kp_row_out !== 4'b0111) begin errors++; $display("FAIL mid_rst_row got %b exp 0111", kp.kp_row_out); end
      @(negedge clock_in) reset_in = 1'b0;
      s0 = strobes;
      wait_edges(63);
      checks++; if ({kp.coluna_out, kp.linha_out} !== 7'b0) begin errors++; $display("FAIL mid_early got %b exp 0", {kp.coluna_out, kp.linha_out}); end
      wait_edges(1);
      checks++; if ({kp.coluna_out, kp.linha_out} !== 7'b001_1000) begin errors++; $display("FAIL mid_rereport got %b exp 0011000", {kp.coluna_out, kp.linha_out}); end
      checks++; if (kp.key_strobe_out !== 1'b1) begin errors++; $display("FAIL mid_strobe got %b exp 1", kp.key_strobe_out); end
      wait_edges(2);
      checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL mid_pulses got %0d exp 1", strobes - s0); end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_hold_5();
      test_bounce();
      test_two_keys();
      test_star_release();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
